// File: rtl/rect_motion_ctl.sv
// Frame-synchronous drop/bounce controller producing the rectangle's ypos.
// Position and velocity move only on the vblnk rising edge, so the drawn frame never tears.
module rect_motion_ctl #(
  parameter int unsigned Y_FLOOR = 535,
  parameter int unsigned ACCEL   = 1,
  parameter int unsigned VEL_MIN = 2,
  parameter int unsigned VEL_MAX = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic        start,
  input  logic        stop,
  input  logic [11:0] y_init,
  output logic [11:0] ypos,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, FALL, RISE, DONE} state_e;

  localparam logic [12:0] FLOOR13 = 13'(Y_FLOOR);
  localparam logic [11:0] FLOOR12 = 12'(Y_FLOOR);
  localparam logic [12:0] ACC13   = 13'(ACCEL);
  localparam logic [11:0] ACC12   = 12'(ACCEL);
  localparam logic [12:0] VMIN13  = 13'(VEL_MIN);
  localparam logic [12:0] VMAX13  = 13'(VEL_MAX);

  state_e      state_q, state_d;
  logic [11:0] ypos_q, ypos_d;
  logic [11:0] vel_q, vel_d;
  logic        vblnk_d_q, vblnk_d_d;
  logic        done_q, done_d;

  logic        tick;
  logic [12:0] v_inc, v_sat, y_sum, v_half, y_init13;
  logic [11:0] vel_dec;

  always_comb begin
    vblnk_d_d = vblnk;
    tick      = vblnk & ~vblnk_d_q;
    state_d   = state_q;
    ypos_d    = ypos_q;
    vel_d     = vel_q;
    done_d    = 1'b0;

    // 13-bit sums keep the floor comparison free of wraparound
    y_init13 = {1'b0, y_init};
    v_inc    = {1'b0, vel_q} + ACC13;
    v_sat    = (v_inc > VMAX13) ? VMAX13 : v_inc;
    y_sum    = {1'b0, ypos_q} + v_sat;
    v_half   = v_sat >> 1;
    vel_dec  = (vel_q > ACC12) ? (vel_q - ACC12) : 12'd0;

    if (stop) begin
      state_d = IDLE;
      vel_d   = 12'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // a tick coincident with start is dropped; motion begins next frame
          if (start) begin
            ypos_d  = (y_init13 > FLOOR13) ? FLOOR12 : y_init;
            vel_d   = 12'd0;
            state_d = FALL;
          end
        end
        FALL: begin
          if (tick) begin
            if (y_sum < FLOOR13) begin
              ypos_d = y_sum[11:0];
              vel_d  = v_sat[11:0];
            end else begin
              ypos_d = FLOOR12;
              if (v_half >= VMIN13) begin
                vel_d   = v_half[11:0];
                state_d = RISE;
              end else begin
                vel_d   = 12'd0;
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        RISE: begin
          if (tick) begin
            if (vel_q > ypos_q) begin
              ypos_d  = 12'd0;
              vel_d   = 12'd0;
              state_d = FALL;
            end else begin
              ypos_d = ypos_q - vel_q;
              vel_d  = vel_dec;
              if (vel_dec == 12'd0) state_d = FALL;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ypos_q    <= 12'd0;
      vel_q     <= 12'd0;
      vblnk_d_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ypos_q    <= ypos_d;
      vel_q     <= vel_d;
      vblnk_d_q <= vblnk_d_d;
      done_q    <= done_d;
    end
  end

  assign ypos = ypos_q;
  assign busy = (state_q == FALL) || (state_q == RISE);
  assign done = done_q;

endmodule

// File: tb/tb_rect_motion_ctl.sv
// Directed-vector bench for rect_motion_ctl: frame-level ops with hand-computed
// ypos/busy/done-count expectations, plus a clock-stopped reset sequence.
module tb_rect_motion_ctl;

  typedef enum logic [2:0] {OP_START, OP_FRAME, OP_STOP, OP_STOP_TICK, OP_START_TICK} op_e;
  typedef struct {
    op_e         op;
    logic [11:0] yi;
    logic [11:0] ey;
    logic        eb;
    int          ed;
  } vec_t;

  logic        clk = 1'b0, clk_run = 1'b1;
  logic        rst_n, vblnk, start, stop;
  logic [11:0] y_init, ypos;
  logic        busy, done;

  int n_vec = 0, n_err = 0, done_cnt = 0;
  vec_t vt[$];

  rect_motion_ctl dut (
    .clk(clk), .rst_n(rst_n), .vblnk(vblnk), .start(start), .stop(stop),
    .y_init(y_init), .ypos(ypos), .busy(busy), .done(done)
  );

  always #5 if (clk_run) clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
    if (ypos > 12'd535) begin
      n_err++;
      $display("FAIL ypos_bound: got %0d, limit 535", ypos);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic void add(input op_e op, input int yi, input int ey, input logic eb, input int ed);
    vec_t v;
    v.op = op; v.yi = 12'(yi); v.ey = 12'(ey); v.eb = eb; v.ed = ed;
    vt.push_back(v);
  endfunction

  int bounce[20] = '{501, 503, 506, 510, 515, 521, 528, 535, 531, 528,
                     526, 525, 526, 528, 531, 535, 533, 532, 533, 535};

  initial begin
    rst_n = 1'b0; vblnk = 1'b0; start = 1'b0; stop = 1'b0; y_init = 12'd0;

    // free fall, plain stop, then stop coincident with tick 5
    add(OP_START, 100, 100, 1, 0);
    add(OP_FRAME, 0, 101, 1, 0);
    add(OP_FRAME, 0, 103, 1, 0);
    add(OP_FRAME, 0, 106, 1, 0);
    add(OP_FRAME, 0, 110, 1, 0);
    add(OP_FRAME, 0, 115, 1, 0);
    add(OP_STOP,  0, 115, 0, 0);
    add(OP_START, 100, 100, 1, 0);
    add(OP_FRAME, 0, 101, 1, 0);
    add(OP_FRAME, 0, 103, 1, 0);
    add(OP_FRAME, 0, 106, 1, 0);
    add(OP_FRAME, 0, 110, 1, 0);
    add(OP_STOP_TICK, 0, 110, 0, 0);
    add(OP_FRAME, 0, 110, 0, 0);
    // immediate settle
    add(OP_START, 530, 530, 1, 0);
    add(OP_FRAME, 0, 531, 1, 0);
    add(OP_FRAME, 0, 533, 1, 0);
    add(OP_FRAME, 0, 535, 0, 1);
    add(OP_FRAME, 0, 535, 0, 1);
    // start+tick from DONE with clamped y_init; next tick settles at once
    add(OP_START_TICK, 700, 535, 1, 1);
    add(OP_FRAME, 0, 535, 0, 2);
    // bounce, with an ignored start (y_init=0) during FALL after tick 3
    add(OP_START, 500, 500, 1, 2);
    for (int i = 0; i < 20; i++) begin
      add(OP_FRAME, 0, bounce[i], (i != 19), (i == 19) ? 3 : 2);
      if (i == 2) add(OP_START, 0, 506, 1, 2);
    end
    // restart from DONE at the ceiling
    add(OP_START, 0, 0, 1, 3);
    add(OP_FRAME, 0, 1, 1, 3);
    add(OP_FRAME, 0, 3, 1, 3);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // asynchronous reset mid-FALL with the clock stopped
    n_vec++;
    start = 1'b1; y_init = 12'd200;
    @(negedge clk);
    start = 1'b0;
    vblnk = 1'b1;
    @(negedge clk);
    chk("rst_pre_ypos", 32'(ypos), 32'd201);
    vblnk = 1'b0;
    repeat (3) @(negedge clk);
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_ypos", 32'(ypos), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    vblnk = 1'b1;
    #3 rst_n = 1'b1;
    clk_run = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_rel_ypos", 32'(ypos), 32'd0);
    chk("rst_rel_busy", 32'(busy), 32'd0);
    vblnk = 1'b0;
    repeat (5) @(negedge clk);

    foreach (vt[i]) begin
      n_vec++;
      case (vt[i].op)
        OP_START: begin
          start = 1'b1; y_init = vt[i].yi;
          @(negedge clk);
          start = 1'b0;
        end
        OP_STOP: begin
          stop = 1'b1;
          @(negedge clk);
          stop = 1'b0;
        end
        default: begin
          vblnk = 1'b1;
          start = (vt[i].op == OP_START_TICK);
          stop  = (vt[i].op == OP_STOP_TICK);
          y_init = vt[i].yi;
          @(negedge clk);
          start = 1'b0; stop = 1'b0;
          chk($sformatf("v%0d ypos_upd", i), 32'(ypos), 32'(vt[i].ey));
          repeat (49) @(negedge clk);
          chk($sformatf("v%0d ypos_hold", i), 32'(ypos), 32'(vt[i].ey));
          vblnk = 1'b0;
          repeat (10) @(negedge clk);
        end
      endcase
      chk($sformatf("v%0d ypos", i), 32'(ypos), 32'(vt[i].ey));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].eb));
      chk($sformatf("v%0d done_cnt", i), 32'(done_cnt), 32'(vt[i].ed));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rect_motion_ctl.md
# rect_motion_ctl

Frame-synchronous motion controller that generates the `ypos` input of the rectangle drawer. It drops the rectangle under constant acceleration and bounces it off a floor line with velocity halving until it settles. The block sits beside the VGA timing chain and samples only `vblnk`. It updates `ypos` once per frame, at the start of vertical blanking, so the drawn rectangle never tears.

## Interface
- `Y_FLOOR`, 535: lowest allowed `ypos`, i.e. the floor line (600 − 64 − 1).
- `ACCEL`, 1: velocity increment per frame, in px/frame.
- `VEL_MIN`, 2: minimum rebound velocity; any rebound below this ends the motion.
- `VEL_MAX`, 31: velocity saturation value.
- `clk`  in  1: pixel clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `vblnk`  in  1: vertical blanking from the timing chain.
- `start`  in  1: level-sampled request; starts a drop from `y_init`.
- `stop`  in  1: abort; returns to IDLE and freezes `ypos`.
- `y_init`  in  12: start position, latched on an accepted `start`.
- `ypos`  out  12: rectangle top edge, to the drawer.
- `busy`  out  1: high in FALL and RISE.
- `done`  out  1: one-cycle pulse when the rectangle settles.

## Operation
- Frame tick: `tick = vblnk & ~vblnk_d`, where `vblnk_d` is `vblnk` registered. There is exactly one tick per blanking interval, however long `vblnk` stays high.
- Internal state: a `vel` register, 12 bits wide. All position arithmetic is done in 13 bits unsigned before clamping.
- States are IDLE, FALL, RISE and DONE. `busy` = (state is FALL or RISE).
- **IDLE / DONE, on `start`:**
  - `ypos <= min(y_init, Y_FLOOR)`.
  - `vel <= 0`.
  - Go to FALL.
  - `start` is ignored in FALL and RISE.
- **FALL, on tick:**
  - `v = min(vel + ACCEL, VEL_MAX)`, `y = ypos + v`.
  - If `y < Y_FLOOR`: `ypos <= y`, `vel <= v`.
  - Otherwise: `ypos <= Y_FLOOR` and `r = v >> 1`.
    - If `r >= VEL_MIN`: `vel <= r`, go to RISE.
    - Otherwise: `vel <= 0`, go to DONE, pulse `done`.
- **RISE, on tick:**
  - If `vel > ypos`: `ypos <= 0`, `vel <= 0`, go to FALL (ceiling clamp).
  - Otherwise: `ypos <= ypos − vel`, `vel <= vel − ACCEL`, saturating at 0.
    - If the new `vel` is 0, go to FALL.
- **DONE:** `ypos` holds `Y_FLOOR`, `busy` = 0.
- **`stop`, any state:**
  - Go to IDLE, `vel <= 0`, `ypos` holds.
  - No `done` pulse.
- Priority: `stop` > `start` > tick. In IDLE/DONE, a tick arriving in the same cycle as `start` is discarded; the first motion update uses the next tick.

## Timing
- Reset, asynchronous: state = IDLE, `ypos` = 0, `vel` = 0, `vblnk_d` = 0, `busy` = 0, `done` = 0.
  - Mid-motion reset aborts immediately.
  - A tick seen on release while in IDLE has no effect.
- `start` sampled at edge N: `ypos` = clamped `y_init` and `busy` = 1 after edge N.
- Tick update: if `vblnk` is first sampled high at edge N, `ypos`, `vel` and state update at edge N. This gives one cycle of latency from the `vblnk` rise, well inside blanking.
- `done` is high for exactly the one cycle following the edge that enters DONE. `busy` falls at the same edge.
- `ypos` changes only on a tick, an accepted `start`, or reset. It is constant between updates and never exceeds `Y_FLOOR`.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-FALL with no clock running.
  - Expect `ypos` = 0, `busy` = 0, `done` = 0 immediately.
  - After release with `vblnk` = 1, expect no motion.
- **Free fall:** `y_init` = 100, `start`, then 5 frames.
  - Expect `ypos` = 101, 103, 106, 110, 115.
  - `busy` = 1 throughout; `vblnk` held high for 50 cycles per frame gives a single update each frame.
- **Immediate settle:** `y_init` = 530.
  - Expect `ypos` = 531, 533, then 535 on the third tick (v = 3, r = 1 < 2).
  - `done` pulses once and `busy` → 0.
- **Bounce sequence:** `y_init` = 500, 20 ticks.
  - Ticks 1–8: `ypos` = 501, 503, 506, 510, 515, 521, 528, 535. Tick 8 enters RISE with `vel` = 4.
  - Ticks 9–12: 531, 528, 526, 525, then FALL.
  - Ticks 13–16: 526, 528, 531, 535. Tick 16 enters RISE with `vel` = 2.
  - Ticks 17–18: 533, 532, then FALL.
  - Ticks 19–20: 533, 535. Tick 20 enters DONE and `done` pulses.
- **Abort and priority:**
  - `stop` at tick 5 of the free-fall case, coincident with the tick: expect `ypos` frozen at 110, IDLE, no `done`.
  - `start` plus tick in the same cycle with `y_init` = 700: expect `ypos` = 535 (clamped), no tick update applied that cycle.
- **Ignored start:** `start` with `y_init` = 0 pulsed during FALL.
  - Expect no change to the trajectory.
  - After DONE, a new `start` with `y_init` = 0 restarts the drop: `ypos` = 0, then 1, 3, … on successive ticks.
